// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request arbiter.
package irq_pkg;

  localparam int NUM_IRQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } irq_state_t;

  // Highest set bit wins; all-zero input yields all-zero output.
  function automatic logic [NUM_IRQ-1:0] prio_onehot(input logic [NUM_IRQ-1:0] v);
    logic [NUM_IRQ-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_capture.sv
// Request capture: previous-cycle sample, edge/level set vector, and the
// pending register where a same-cycle set overrides a clear.
module irq_edge_capture
  import irq_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] req_in,
  input  logic [NUM_IRQ-1:0] clr,
  output logic [NUM_IRQ-1:0] pend
);

  logic [NUM_IRQ-1:0] r_req_q;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] w_set;

  // req_q resets to 0 so a line already high at reset release counts as an edge.
  assign w_set = (EDGE_MODE != 0) ? (req_in & ~r_req_q) : req_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= '0;
      r_pend  <= '0;
    end else begin
      r_req_q <= req_in;
      r_pend  <= (r_pend & ~clr) | w_set;
    end
  end

  assign pend = r_pend;

endmodule

// File: rtl/irq_onehot_arbiter.sv
// Fixed-priority, non-preemptive one-hot arbiter feeding a 4-to-2 encoder;
// grant is held until ack and every grant is followed by one idle cycle.
module irq_onehot_arbiter
  import irq_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] req_in,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               ack,
  output logic [NUM_IRQ-1:0] grant,
  output logic               grant_en,
  output logic [NUM_IRQ-1:0] pend
);

  irq_state_t         r_state, w_state_d;
  logic [NUM_IRQ-1:0] r_grant, w_grant_d;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_sel;
  logic [NUM_IRQ-1:0] w_clr;

  // Clear only on an accepted ack; ack in IDLE must not touch pend.
  assign w_clr = (r_state == GRANT && ack) ? r_grant : '0;

  irq_edge_capture #(.EDGE_MODE(EDGE_MODE)) u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_in (req_in),
    .clr    (w_clr),
    .pend   (w_pend)
  );

  assign w_elig = w_pend & ~mask;
  assign w_sel  = prio_onehot(w_elig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    case (r_state)
      IDLE: begin
        w_grant_d = '0;
        if (w_elig != '0) begin
          w_grant_d = w_sel;
          w_state_d = GRANT;
        end
      end
      GRANT: begin
        // No preemption: selection and mask changes are ignored until ack.
        if (ack) begin
          w_grant_d = '0;
          w_state_d = IDLE;
        end
      end
      default: begin
        w_grant_d = '0;
        w_state_d = IDLE;
      end
    endcase
  end

  assign grant    = r_grant;
  assign grant_en = (r_state == GRANT);
  assign pend     = w_pend;

endmodule

// File: tb/tb_irq_onehot_arbiter.sv
// Directed bench: edge-mode instance for the main scenarios, level-mode
// instance for repeated re-grant of a held line.
module tb_irq_onehot_arbiter;
  import irq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in, mask;
  logic       ack;
  logic [3:0] grant, pend;
  logic       grant_en;
  logic [3:0] l_req, l_grant, l_pend;
  logic       l_ack, l_grant_en;

  int n_pass = 0;
  int n_chk  = 0;

  irq_onehot_arbiter #(.EDGE_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack),
    .grant(grant), .grant_en(grant_en), .pend(pend)
  );

  irq_onehot_arbiter #(.EDGE_MODE(0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req_in(l_req), .mask(4'b0000), .ack(l_ack),
    .grant(l_grant), .grant_en(l_grant_en), .pend(l_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Build a grant on bit 2, then reset mid-GRANT.
    req_in = 4'b0100; tick();
    req_in = 4'b0000;
    n_chk++; if (grant_en !== 1'b0) $display("FAIL rst_lat_en got=%b exp=0", grant_en); else n_pass++;
    tick();
    n_chk++; if (grant !== 4'b0100 || grant_en !== 1'b1) $display("FAIL rst_pre_grant got=%b/%b exp=0100/1", grant, grant_en); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (grant !== 4'b0000 || grant_en !== 1'b0 || pend !== 4'b0000) $display("FAIL rst_async got=%b/%b/%b exp=0000/0/0000", grant, grant_en, pend); else n_pass++;
    req_in = 4'b0001;
    #1 rst_n = 1'b1;
    tick();
    n_chk++; if (pend !== 4'b0001 || grant_en !== 1'b0) $display("FAIL rst_first_edge got=%b/%b exp=0001/0", pend, grant_en); else n_pass++;
    tick();
    n_chk++; if (grant !== 4'b0001) $display("FAIL rst_grant got=%b exp=0001", grant); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0; req_in = 4'b0000;
    n_chk++; if (pend !== 4'b0000 || grant_en !== 1'b0) $display("FAIL rst_ack got=%b/%b exp=0000/0", pend, grant_en); else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    req_in = 4'b0110; tick();
    req_in = 4'b0000;
    n_chk++; if (pend !== 4'b0110 || grant_en !== 1'b0) $display("FAIL prio_pend got=%b/%b exp=0110/0", pend, grant_en); else n_pass++;
    tick();
    n_chk++; if (grant !== 4'b0100 || grant_en !== 1'b1) $display("FAIL prio_first got=%b/%b exp=0100/1", grant, grant_en); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0;
    n_chk++; if (grant !== 4'b0000 || grant_en !== 1'b0 || pend !== 4'b0010) $display("FAIL prio_gap got=%b/%b/%b exp=0000/0/0010", grant, grant_en, pend); else n_pass++;
    tick();
    n_chk++; if (grant !== 4'b0010 || grant_en !== 1'b1) $display("FAIL prio_second got=%b/%b exp=0010/1", grant, grant_en); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0;
    n_chk++; if (pend !== 4'b0000 || grant_en !== 1'b0) $display("FAIL prio_drain got=%b/%b exp=0000/0", pend, grant_en); else n_pass++;
    tick();
    n_chk++; if (grant_en !== 1'b0 || grant !== 4'b0000) $display("FAIL prio_idle got=%b/%b exp=0000/0", grant, grant_en); else n_pass++;
  endtask

  task automatic test_no_preempt();
    req_in = 4'b0001; tick();
    req_in = 4'b0000; tick();
    n_chk++; if (grant !== 4'b0001) $display("FAIL npre_start got=%b exp=0001", grant); else n_pass++;
    req_in = 4'b1000; tick();
    req_in = 4'b0000;
    n_chk++; if (grant !== 4'b0001 || pend !== 4'b1001) $display("FAIL npre_hold1 got=%b/%b exp=0001/1001", grant, pend); else n_pass++;
    tick(); tick();
    n_chk++; if (grant !== 4'b0001 || grant_en !== 1'b1) $display("FAIL npre_hold2 got=%b/%b exp=0001/1", grant, grant_en); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0;
    n_chk++; if (grant_en !== 1'b0) $display("FAIL npre_gap got=%b exp=0", grant_en); else n_pass++;
    tick();
    n_chk++; if (grant !== prio_onehot(4'b1000)) $display("FAIL npre_next got=%b exp=1000", grant); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  task automatic test_mask();
    mask = 4'b1000;
    req_in = 4'b1001; tick();
    req_in = 4'b0000; tick();
    n_chk++; if (grant !== 4'b0001 || pend !== 4'b1001) $display("FAIL mask_low got=%b/%b exp=0001/1001", grant, pend); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    n_chk++; if (grant_en !== 1'b0 || pend !== 4'b1000) $display("FAIL mask_block got=%b/%b exp=0/1000", grant_en, pend); else n_pass++;
    mask = 4'b0000; tick();
    n_chk++; if (grant !== 4'b1000 || grant_en !== 1'b1) $display("FAIL mask_clear got=%b/%b exp=1000/1", grant, grant_en); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  task automatic test_set_over_clear();
    req_in = 4'b0010; tick();
    req_in = 4'b0000; tick();
    n_chk++; if (grant !== 4'b0010) $display("FAIL soc_grant got=%b exp=0010", grant); else n_pass++;
    ack = 1'b1; req_in = 4'b0010; tick();
    ack = 1'b0; req_in = 4'b0000;
    n_chk++; if (pend !== 4'b0010 || grant_en !== 1'b0) $display("FAIL soc_keep got=%b/%b exp=0010/0", pend, grant_en); else n_pass++;
    tick();
    n_chk++; if (grant !== 4'b0010 || grant_en !== 1'b1) $display("FAIL soc_regrant got=%b/%b exp=0010/1", grant, grant_en); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0;
    n_chk++; if (pend !== 4'b0000) $display("FAIL soc_drain got=%b exp=0000", pend); else n_pass++;
    tick();
  endtask

  task automatic test_spurious_ack();
    ack = 1'b1; tick(); tick();
    n_chk++; if (grant_en !== 1'b0 || grant !== 4'b0000 || pend !== 4'b0000) $display("FAIL spur_empty got=%b/%b/%b exp=0/0000/0000", grant_en, grant, pend); else n_pass++;
    // Pending but masked: ack in IDLE must not clear it.
    mask = 4'b0100; req_in = 4'b0100; tick();
    req_in = 4'b0000; tick();
    n_chk++; if (pend !== 4'b0100 || grant_en !== 1'b0) $display("FAIL spur_masked got=%b/%b exp=0100/0", pend, grant_en); else n_pass++;
    ack = 1'b0; mask = 4'b0000; tick();
    n_chk++; if (grant !== 4'b0100) $display("FAIL spur_unmask got=%b exp=0100", grant); else n_pass++;
    ack = 1'b1; tick();
    ack = 1'b0; tick();
  endtask

  task automatic test_level();
    l_req = 4'b0100; tick();
    n_chk++; if (l_pend !== 4'b0100 || l_grant_en !== 1'b0) $display("FAIL lvl_pend got=%b/%b exp=0100/0", l_pend, l_grant_en); else n_pass++;
    tick();
    n_chk++; if (l_grant !== 4'b0100) $display("FAIL lvl_first got=%b exp=0100", l_grant); else n_pass++;
    l_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ((i % 2) == 0) begin
        if (l_grant_en !== 1'b0 || l_grant !== 4'b0000 || l_pend !== 4'b0100) $display("FAIL lvl_gap%0d got=%b/%b/%b exp=0/0000/0100", i, l_grant_en, l_grant, l_pend); else n_pass++;
      end else begin
        if (l_grant_en !== 1'b1 || l_grant !== 4'b0100) $display("FAIL lvl_regrant%0d got=%b/%b exp=1/0100", i, l_grant_en, l_grant); else n_pass++;
      end
    end
    l_req = 4'b0000; tick(); l_ack = 1'b0; tick();
    n_chk++; if (l_pend !== 4'b0000 || l_grant_en !== 1'b0) $display("FAIL lvl_drain got=%b/%b exp=0000/0", l_pend, l_grant_en); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; mask = '0; ack = 1'b0;
    l_req = '0; l_ack = 1'b0;
    tick(); tick();
    n_chk++; if (grant !== 4'b0000 || grant_en !== 1'b0 || pend !== 4'b0000) $display("FAIL reset_state got=%b/%b/%b exp=0000/0/0000", grant, grant_en, pend); else n_pass++;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_priority();
    test_no_preempt();
    test_mask();
    test_set_over_clear();
    test_spurious_ack();
    test_level();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
